// File: rtl/fpu_div16.sv
// ============================================================================
// Module   : fpu_div16
// Purpose  : Sequential IEEE-754 binary16 divider coprocessor,
//            fpuOut = fpuIn1 / fpuIn2. Restoring radix-2 significand divide
//            (one quotient bit per clock), round-to-nearest-even,
//            flush-to-zero on subnormal inputs.
// Ports    : clock         - system clock, rising edge
//            reset         - synchronous active-low reset
//            start         - begin an operation (accepted in IDLE/DONE)
//            fpuIn1/fpuIn2 - dividend / divisor, latched on the start edge
//            fpuOut        - quotient, valid while done==1
//            done          - result valid, held until next accepted start
//            condCodes     - {Z, C, N, V}
//            opStatusFlags - {invalid, divByZero, overflow, underflow, inexact}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_div16 #(
  parameter int QBITS = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] fpuIn1,
  input  logic [15:0] fpuIn2,
  output logic [15:0] fpuOut,
  output logic        done,
  output logic [3:0]  condCodes,
  output logic [4:0]  opStatusFlags
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q;
  logic [15:0]        a_q, b_q;
  logic [11:0]        rem_q;
  logic [QBITS-1:0]   quo_q;
  logic [CW-1:0]      cnt_q;
  logic signed [6:0]  exp_q;

  function automatic logic [3:0] cc_of(input logic [15:0] r, input logic ovf);
    return {(r[14:0] == 15'd0), 1'b0, r[15], ovf};
  endfunction

  // ---------------- operand classification ----------------
  logic              sign_d;
  logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic              spec_d;
  logic [15:0]       spec_res_d;
  logic [4:0]        spec_flags_d;
  logic signed [6:0] exp_init_d;

  always_comb begin
    sign_d       = a_q[15] ^ b_q[15];
    a_nan        = (&a_q[14:10]) & (|a_q[9:0]);
    a_inf        = (&a_q[14:10]) & ~(|a_q[9:0]);
    a_zero       = ~(|a_q[14:10]);            // subnormals flush to zero
    b_nan        = (&b_q[14:10]) & (|b_q[9:0]);
    b_inf        = (&b_q[14:10]) & ~(|b_q[9:0]);
    b_zero       = ~(|b_q[14:10]);
    spec_d       = 1'b1;
    spec_res_d   = 16'h0000;
    spec_flags_d = 5'b00000;
    exp_init_d   = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]}) + 7'sd15;
    if (a_nan | b_nan) begin
      spec_res_d = 16'h7E00;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_res_d   = 16'h7E00;
      spec_flags_d = 5'b10000;
    end else if (a_inf) begin
      // divisor is finite here (inf/inf handled above), including zero
      spec_res_d = {sign_d, 15'h7C00};
    end else if (b_zero) begin
      spec_res_d   = {sign_d, 15'h7C00};
      spec_flags_d = 5'b01000;
    end else if (a_zero | b_inf) begin
      spec_res_d = {sign_d, 15'h0000};
    end else begin
      spec_d = 1'b0;
    end
  end

  // ---------------- one restoring divide step ----------------
  logic        ge_d;
  logic [11:0] sub_d, rem_d;

  always_comb begin
    ge_d  = rem_q >= {1'b0, 1'b1, b_q[9:0]};
    sub_d = rem_q - {1'b0, 1'b1, b_q[9:0]};
    // remainder is always below the divisor (< 2^11) before the shift
    rem_d = ge_d ? {sub_d[10:0], 1'b0} : {rem_q[10:0], 1'b0};
  end

  // ---------------- normalise / round / range ----------------
  logic [9:0]        mant_n, mant_r;
  logic              guard_n, sticky_n, rnd_up, inexact_d;
  logic [10:0]       mant_inc;
  logic signed [6:0] exp_n, exp_r;
  logic [15:0]       res_d;
  logic [4:0]        flags_d;

  always_comb begin
    if (quo_q[QBITS-1]) begin
      mant_n   = quo_q[QBITS-2 -: 10];
      guard_n  = quo_q[QBITS-12];
      sticky_n = (|quo_q[QBITS-13:0]) | (|rem_q);
      exp_n    = exp_q;
    end else begin
      mant_n   = quo_q[QBITS-3 -: 10];
      guard_n  = quo_q[QBITS-13];
      sticky_n = (|quo_q[QBITS-14:0]) | (|rem_q);
      exp_n    = exp_q - 7'sd1;
    end
    rnd_up    = guard_n & (sticky_n | mant_n[0]);
    inexact_d = guard_n | sticky_n;
    mant_inc  = {1'b0, mant_n} + {10'd0, rnd_up};
    if (mant_inc[10]) begin
      mant_r = 10'd0;
      exp_r  = exp_n + 7'sd1;
    end else begin
      mant_r = mant_inc[9:0];
      exp_r  = exp_n;
    end
    if (exp_r >= 7'sd31) begin
      res_d   = {sign_d, 15'h7C00};
      flags_d = 5'b00101;
    end else if (exp_r <= 7'sd0) begin
      res_d   = {sign_d, 15'h0000};
      flags_d = 5'b00011;
    end else begin
      res_d   = {sign_d, exp_r[4:0], mant_r};
      flags_d = {4'b0000, inexact_d};
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      a_q           <= 16'h0000;
      b_q           <= 16'h0000;
      rem_q         <= 12'd0;
      quo_q         <= '0;
      cnt_q         <= '0;
      exp_q         <= 7'sd0;
      fpuOut        <= 16'h0000;
      done          <= 1'b0;
      condCodes     <= 4'b0000;
      opStatusFlags <= 5'b00000;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q           <= fpuIn1;
            b_q           <= fpuIn2;
            done          <= 1'b0;
            condCodes     <= 4'b0000;
            opStatusFlags <= 5'b00000;
            state_q       <= S_PREP;
          end
        end
        S_PREP: begin
          if (spec_d) begin
            fpuOut        <= spec_res_d;
            opStatusFlags <= spec_flags_d;
            condCodes     <= cc_of(spec_res_d, 1'b0);
            done          <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            rem_q   <= {2'b01, a_q[9:0]};
            quo_q   <= '0;
            cnt_q   <= CW'(QBITS - 1);
            exp_q   <= exp_init_d;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          // quotient bits arrive MSB first, so shifting in from the right
          // leaves the first bit at quo_q[QBITS-1] after QBITS steps
          quo_q <= {quo_q[QBITS-2:0], ge_d};
          rem_q <= rem_d;
          if (cnt_q == '0) begin
            state_q <= S_ROUND;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ROUND: begin
          fpuOut        <= res_d;
          opStatusFlags <= flags_d;
          condCodes     <= cc_of(res_d, flags_d[2]);
          done          <= 1'b1;
          state_q       <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_div16.sv
// ============================================================================
// Module   : tb_fpu_div16
// Purpose  : Self-checking bench for fpu_div16. Directed operations with
//            hand-computed literal results, plus a per-cycle comparison of
//            the held result against an exact-division reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_div16;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] fpuIn1, fpuIn2;
  logic [15:0] fpuOut;
  logic        done;
  logic [3:0]  condCodes;
  logic [4:0]  opStatusFlags;

  int errors = 0;
  int checks = 0;

  logic        exp_valid = 1'b0;
  logic [15:0] exp_res;
  logic [4:0]  exp_fl;
  logic [3:0]  exp_cc;

  fpu_div16 #(.QBITS(14)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .fpuIn1       (fpuIn1),
    .fpuIn2       (fpuIn2),
    .fpuOut       (fpuOut),
    .done         (done),
    .condCodes    (condCodes),
    .opStatusFlags(opStatusFlags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: exact rational division of the 11-bit significands with a
  // very wide quotient, then IEEE round-to-nearest-even on that value.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [4:0] f);
    logic s;
    int ea, eb, e;
    bit an, ai, az, bn, bi, bz, g, st;
    longint unsigned ma, mb, quo, rem, sig, lowmask;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    an = (ea == 31) && (a[9:0] != 0);
    ai = (ea == 31) && (a[9:0] == 0);
    az = (ea == 0);
    bn = (eb == 31) && (b[9:0] != 0);
    bi = (eb == 31) && (b[9:0] == 0);
    bz = (eb == 0);
    f  = 5'b00000;
    if (an || bn)                   r = 16'h7E00;
    else if ((az && bz) || (ai && bi)) begin r = 16'h7E00; f = 5'b10000; end
    else if (ai)                    r = {s, 15'h7C00};
    else if (bz)                    begin r = {s, 15'h7C00}; f = 5'b01000; end
    else if (az || bi)              r = {s, 15'h0000};
    else begin
      ma  = 64'd1024 + longint'(a[9:0]);
      mb  = 64'd1024 + longint'(b[9:0]);
      quo = (ma << 40) / mb;          // ratio * 2^40
      rem = (ma << 40) % mb;
      if (ma >= mb) begin
        e = ea - eb + 15;
        sig = quo >> 30;
        g = quo[29];
        lowmask = (64'd1 << 29) - 64'd1;
      end else begin
        e = ea - eb + 14;
        sig = quo >> 29;
        g = quo[28];
        lowmask = (64'd1 << 28) - 64'd1;
      end
      st = ((quo & lowmask) != 0) || (rem != 0);
      if (g && (st || sig[0])) sig = sig + 1;
      if (sig == 64'd2048) begin sig = 64'd1024; e = e + 1; end
      if (e >= 31)     begin r = {s, 15'h7C00}; f = 5'b00101; end
      else if (e <= 0) begin r = {s, 15'h0000}; f = 5'b00011; end
      else begin
        r = {s, 5'(e), 10'(sig)};
        f = {4'b0000, (g || st)};
      end
    end
  endfunction

  // Held result checked against the model on every cycle done is high.
  always @(negedge clock) begin
    if (exp_valid && done === 1'b1) begin
      chk("model_fpuOut", fpuOut, exp_res);
      chk("model_flags", {11'd0, opStatusFlags}, {11'd0, exp_fl});
      chk("model_cc", {12'd0, condCodes}, {12'd0, exp_cc});
    end
  end

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] lit_res, input logic [4:0] lit_fl,
                        input logic [3:0] lit_cc, input int lat, input bit disturb);
    int n;
    bit got;
    @(negedge clock);
    fpuIn1 = a;
    fpuIn2 = b;
    start  = 1'b1;
    @(posedge clock);
    model(a, b, exp_res, exp_fl);
    exp_cc    = {(exp_res[14:0] == 15'd0), 1'b0, exp_res[15], exp_fl[2]};
    exp_valid = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clock);
      if (disturb && n < 14) begin
        start  = 1'($urandom_range(0, 1));
        fpuIn1 = 16'($urandom);
        fpuIn2 = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      n++;
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    chk({name, "_latency"}, 16'(n), 16'(lat));
    chk({name, "_res"}, fpuOut, lit_res);
    chk({name, "_flags"}, {11'd0, opStatusFlags}, {11'd0, lit_fl});
    chk({name, "_cc"}, {12'd0, condCodes}, {12'd0, lit_cc});
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    fpuIn1 = 16'h0000;
    fpuIn2 = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_fpuOut", fpuOut, 16'h0000);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_cc", {12'd0, condCodes}, 16'd0);
    chk("reset_flags", {11'd0, opStatusFlags}, 16'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("one_by_one",  16'h3C00, 16'h3C00, 16'h3C00, 5'b00000, 4'b0000, 16, 1'b0);
    run_op("one_third",   16'h3C00, 16'h4200, 16'h3555, 5'b00001, 4'b0000, 16, 1'b0);
    run_op("six_neg_two", 16'h4600, 16'hC000, 16'hC200, 5'b00000, 4'b0010, 16, 1'b0);
    run_op("div_zero",    16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 4'b0000, 1,  1'b0);
    run_op("zero_zero",   16'h0000, 16'h0000, 16'h7E00, 5'b10000, 4'b0000, 1,  1'b0);
    run_op("inf_inf",     16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 4'b0000, 1,  1'b0);
    run_op("nan_in",      16'h7E01, 16'h3C00, 16'h7E00, 5'b00000, 4'b0000, 1,  1'b0);
    run_op("inf_fin",     16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 4'b0010, 1,  1'b0);
    run_op("zero_num",    16'h8000, 16'h3C00, 16'h8000, 5'b00000, 4'b1010, 1,  1'b0);
    run_op("overflow",    16'h7BFF, 16'h1400, 16'h7C00, 5'b00101, 4'b0001, 16, 1'b0);
    run_op("underflow",   16'h0400, 16'h7BFF, 16'h0000, 5'b00011, 4'b1000, 16, 1'b0);
    run_op("round_up",    16'h3C00, 16'h3BFF, 16'h3C01, 5'b00001, 4'b0000, 16, 1'b0);

    // Abandon an operation with a reset during the 7th DIVIDE cycle.
    @(negedge clock);
    fpuIn1 = 16'h3C00;
    fpuIn2 = 16'h4200;
    start  = 1'b1;
    @(posedge clock);
    exp_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_fpuOut", fpuOut, 16'h0000);
    chk("midrst_done", {15'd0, done}, 16'd0);
    chk("midrst_cc", {12'd0, condCodes}, 16'd0);
    chk("midrst_flags", {11'd0, opStatusFlags}, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("midrst_idle_done", {15'd0, done}, 16'd0);

    run_op("after_reset", 16'h4000, 16'h4000, 16'h3C00, 5'b00000, 4'b0000, 16, 1'b0);
    run_op("disturbed",   16'h4500, 16'h3C00, 16'h4500, 5'b00000, 4'b0000, 16, 1'b1);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_div16.md
Name: fpu_div16

Overview:
- Sequential IEEE-754 binary16 divider coprocessor: fpuOut = fpuIn1 / fpuIn2.
- Inverse operation to the FP16 multiplier. Shares its start/done coprocessor handshake and its condition-code convention.
- Significands are divided with a restoring radix-2 divider, one quotient bit per cycle, followed by round-to-nearest-even.
- Sits beside the other FPU coprocessors behind the FPU operation dispatch.

Parameters:
- QBITS, 14, number of quotient bits developed: 1 integer bit, 10 fraction bits, guard bit, 2 extra bits.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset: state is reset when reset==0 at posedge.
- start  input  1  begin an operation; sampled only in IDLE or DONE.
- fpuIn1  input  16  dividend {sign, exp[4:0], frac[9:0]}; latched on the start edge.
- fpuIn2  input  16  divisor, same format; latched on the start edge.
- fpuOut  output  16  quotient; registered; valid while done==1.
- done  output  1  result valid; held until the next accepted start.
- condCodes  output  4  {Z, C, N, V}.
- opStatusFlags  output  5  {invalid, divByZero, overflow, underflow, inexact}.

Behaviour:
- Reset (reset==0 at posedge), including mid-operation:
  - state goes to IDLE; the operation in flight is abandoned.
  - fpuOut=0, done=0, condCodes=0, opStatusFlags=0.
- States: IDLE, PREP, DIVIDE, ROUND, DONE.
  - IDLE: start=1 -> latch both inputs, go to PREP, clear done.
  - PREP: classify the operands.
    - Special case -> write the result, go to DONE.
    - Otherwise -> init remainder R={1'b0,1,fracA} (12b), divisor D={1,fracB}, count=13, expDiff=expA-expB+15 (7b signed); go to DIVIDE.
  - DIVIDE: each cycle, if R>=D then q[count]=1, R=(R-D)<<1; else q[count]=0, R=R<<1. count decrements. At count==0 go to ROUND. Exactly 14 cycles.
  - ROUND: normalise, round, register outputs, go to DONE.
  - DONE: done=1, outputs held. start=1 -> latch new inputs, go to PREP, done drops on that edge.
- start is ignored in PREP, DIVIDE and ROUND. Inputs changing after the start edge have no effect.
- Latency, counted from the posedge that samples start:
  - normal operands: done=1 after 16 clocks.
  - special cases: done=1 after 1 clock.
- Subnormal inputs (exp==0) are treated as signed zero (flush-to-zero).
- Special cases resolved in PREP (s = signA^signB):
  - Either operand NaN -> 0x7E00, no flags.
  - 0/0 or inf/inf -> 0x7E00, invalid.
  - finite nonzero / 0 -> {s,0x7C00[14:0]}, divByZero.
  - inf / finite -> signed inf, no flags.
  - 0 / nonzero, or finite / inf -> signed zero, no flags.
- Normalise:
  - q[13]=1: mant=q[12:3], guard=q[2], sticky=|q[1:0] | (R!=0), e=expDiff.
  - q[13]=0: mant=q[11:2], guard=q[1], sticky=q[0] | (R!=0), e=expDiff-1.
- Round to nearest even:
  - Increment mant if guard & (sticky | mant[0]).
  - A carry out of mant sets mant=0 and e=e+1.
  - inexact = guard | sticky.
- Range checks, applied after rounding:
  - e>=31 -> signed inf, overflow=1, inexact=1.
  - e<=0 -> signed zero, underflow=1, inexact=1.
- Condition codes:
  - Z = (fpuOut[14:0]==0).
  - N = fpuOut[15].
  - C = 0.
  - V = overflow flag.
- Flags reflect only the last completed operation and are cleared when a new start is accepted.

Test Plan:
- 0x3C00 / 0x3C00 (1/1) -> fpuOut=0x3C00, flags=0, condCodes=0000; done rises exactly 16 clocks after the start edge.
- 0x3C00 / 0x4200 (1/3) -> fpuOut=0x3555, inexact=1 only; then 0x4600 / 0xC000 (6/-2) -> 0xC200, N=1, flags=0; both issued back to back from DONE.
- 0x3C00 / 0x0000 -> 0x7C00, divByZero=1, done after 1 clock. Also 0x0000 / 0x0000 -> 0x7E00, invalid=1. Also 0x7C00 / 0x7C00 -> 0x7E00, invalid=1.
- 0x7BFF / 0x1400 (65504 / 2^-10) -> 0x7C00, overflow=1, inexact=1, V=1. Also 0x0400 / 0x7BFF -> 0x0000, underflow=1, Z=1.
- Drive reset=0 for one edge during cycle 7 of DIVIDE -> all outputs 0 and state IDLE on the next clock. A fresh start then completes 0x4000/0x4000 -> 0x3C00 in 16 clocks.
- Toggle start and inputs during DIVIDE -> no effect on the result; done stays 0 until the original operation completes.
